// File: rtl/nios_debug_cmd_bridge.sv
// nios_debug_cmd_bridge: carries JTAG update-DR events into the CPU clock
// domain, queues each IR/DR snapshot in a small FIFO and hands commands to the
// OCI core over valid/ready, decoding the IR into one-hot action pulses on pop.
module nios_debug_cmd_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACTION_BIT  = 35,
    localparam int NUM_IR     = 2 ** IR_W,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              udr_toggle,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [DATA_W-1:0] jdo,
    output logic [NUM_IR-1:0] take_action,
    output logic [NUM_IR-1:0] take_no_action,
    output logic [CW-1:0]     cmd_count,
    output logic              overflow,
    input  logic              clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t                 state;
    logic [PW-1:0]          prime_cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   edge_copy;
    logic                   evt;

    logic [IR_W-1:0]        mem_ir [DEPTH];
    logic [DATA_W-1:0]      mem_sr [DEPTH];
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [NUM_IR-1:0]      head_lane;

    assign sync_out = sync[SYNC_STAGES-1];
    // Events are only trusted once PRIME has let the edge copy settle, so a
    // toggle already high at reset never looks like an update-DR.
    assign evt      = (state == RUN) && (sync_out != edge_copy);

    assign full      = (count == CW'(DEPTH));
    assign pop       = (count != '0) && cmd_ready;
    // A full FIFO still accepts the event if the head leaves on the same edge.
    assign push      = evt && (!full || pop);
    assign drop      = evt && full && !pop;
    assign head_lane = NUM_IR'(1) << mem_ir[rptr];

    assign cmd_valid = (count != '0);
    assign cmd_ir    = mem_ir[rptr];
    assign cmd_count = count;

    // Synchronise the TCK-domain toggle and keep a one-cycle-delayed copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync      <= '0;
            edge_copy <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], udr_toggle};
            edge_copy <= sync_out;
        end
    end

    // PRIME lasts SYNC_STAGES+1 cycles after reset, then RUN until next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            case (state)
                PRIME: begin
                    if (prime_cnt == PW'(SYNC_STAGES)) state <= RUN;
                    else prime_cnt <= prime_cnt + PW'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

    // FIFO storage; data needs no reset since pointers gate what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ir[wptr] <= ir_in;
            mem_sr[wptr] <= sr;
        end
    end

    // FIFO pointers and occupancy; power-of-2 depth makes wrap implicit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Latch popped data into jdo and fire a one-cycle decoded IR pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                jdo <= mem_sr[rptr];
                if (mem_sr[rptr][ACTION_BIT]) take_action    <= head_lane;
                else                          take_no_action <= head_lane;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (clear_ovf) overflow <= 1'b0;
    end

endmodule
